// File: rtl/bus_scheduler.sv
// Round-robin arbiter sharing one memory/peripheral bus among NREQ masters,
// one outstanding transaction at a time, with wait-state support and a hung-slave watchdog.
module bus_scheduler #(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned AW      = 64,
  parameter int unsigned DW      = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ*AW-1:0]   req_address_in,
  input  logic [NREQ-1:0]      req_read_in,
  input  logic [NREQ-1:0]      req_write_in,
  input  logic [NREQ*4-1:0]    req_write_mask_in,
  input  logic [NREQ*DW-1:0]   req_write_value_in,
  output logic [NREQ*DW-1:0]   req_read_value_out,
  output logic [NREQ-1:0]      req_ready_out,
  output logic [NREQ-1:0]      req_error_out,
  output logic [AW-1:0]        address_out,
  output logic                 read_out,
  output logic                 write_out,
  output logic [3:0]           write_mask_out,
  output logic [DW-1:0]        write_value_out,
  input  logic [DW-1:0]        read_value_in,
  input  logic                 mem_ready_in,
  output logic [NREQ-1:0]      grant_out
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [NREQ-1:0] grant_q, grant_d;

  logic [NREQ-1:0] active;
  logic [PW-1:0]   pick_idx;
  logic            pick_valid;
  logic [PW-1:0]   gnt_idx;
  logic            busy;
  logic            timeout_hit;
  logic            done;

  assign active      = req_read_in | req_write_in;
  assign busy        = (state_q == BUSY);
  assign timeout_hit = busy && !mem_ready_in && (wait_cnt_q == CW'(TIMEOUT));
  assign done        = busy && (mem_ready_in || timeout_hit);
  assign grant_out   = grant_q;

  // Search starts one past the last serviced requester, wrapping modulo NREQ.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!pick_valid && active[(32'(rr_ptr_q) + k) % NREQ]) begin
        pick_valid = 1'b1;
        pick_idx   = PW'((32'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_q[i]) gnt_idx = PW'(i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= PW'(NREQ - 1);
      wait_cnt_q <= '0;
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
      grant_q    <= grant_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    wait_cnt_d = wait_cnt_q;
    grant_d    = grant_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d    = BUSY;
          grant_d    = NREQ'(1) << pick_idx;
          wait_cnt_d = '0;
        end
      end
      BUSY: begin
        if (done) begin
          state_d    = IDLE;
          grant_d    = '0;
          rr_ptr_d   = gnt_idx;
          wait_cnt_d = '0;
        end else if (wait_cnt_q != CW'(TIMEOUT)) begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write wins when a requester raises both strobes.
  always_comb begin
    address_out        = '0;
    read_out           = 1'b0;
    write_out          = 1'b0;
    write_mask_out     = '0;
    write_value_out    = '0;
    req_read_value_out = '0;
    req_ready_out      = done ? grant_q : '0;
    req_error_out      = timeout_hit ? grant_q : '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (busy && grant_q[i]) begin
        address_out     = req_address_in[i*AW +: AW];
        write_out       = req_write_in[i];
        read_out        = req_read_in[i] & ~req_write_in[i];
        write_mask_out  = req_write_in[i] ? req_write_mask_in[i*4 +: 4] : 4'b0000;
        write_value_out = req_write_value_in[i*DW +: DW];
        if (done) begin
          req_read_value_out[i*DW +: DW] = timeout_hit ? {DW{1'b1}} : read_value_in;
        end
      end
    end
  end

endmodule
